pe_mc_mac: RTL and testbench

//  Next-generation systolic-array PE. Stores DEPTH stationary ifmap words (one per channel), streams

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_mac_pipe.sv | 91 +++++++++
 rtl/pe_mc_mac.sv | 125 ++++++++++++
 tb/tb_pe_mc_mac.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the multi-channel systolic PE.
// Holds the FSM state encoding, default widths and the add-overflow rule.
package pe_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_PSUM_WIDTH = 32;
   localparam int DEF_DEPTH      = 4;

   typedef enum logic {
      LOAD  = 1'b0,
      READY = 1'b1
   } pe_state_e;

   // Width-independent overflow test: sign bits for signed adds, carry-out for unsigned adds.
   function automatic logic add_ovf(input logic i_signed, input logic i_sign_a,
                                    input logic i_sign_b, input logic i_sign_r,
                                    input logic i_carry);
      if (i_signed) begin
         return (i_sign_a == i_sign_b) && (i_sign_r != i_sign_a);
      end
      return i_carry;
   endfunction

endpackage

// File: rtl/pe_mac_pipe.sv
// Two-stage MAC datapath: multiply and capture the psum, then extend, add and
// optionally saturate. Carries a valid bit and a sticky overflow flag.
module pe_mac_pipe
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
   parameter int SAT        = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_fire,
   input  logic                  i_signed,
   input  logic [DATA_WIDTH-1:0] i_ifmap,
   input  logic [DATA_WIDTH-1:0] i_weight,
   input  logic [PSUM_WIDTH-1:0] i_psum,
   input  logic                  i_psum_en,
   output logic [PSUM_WIDTH-1:0] o_psum,
   output logic                  o_psum_en,
   output logic                  o_ovf
);

   localparam int PROD_W = 2 * DATA_WIDTH;

   logic [PROD_W-1:0]     w_a_ext;
   logic [PROD_W-1:0]     w_b_ext;
   logic [PROD_W-1:0]     w_prod;
   logic [PROD_W-1:0]     r_prod;
   logic [PSUM_WIDTH-1:0] r_psum;
   logic                  r_signed;
   logic                  r_v1;
   logic [PSUM_WIDTH-1:0] w_prod_ext;
   logic [PSUM_WIDTH:0]   w_sum;
   logic                  w_ovf;
   logic [PSUM_WIDTH-1:0] w_sat;
   logic [PSUM_WIDTH-1:0] w_result;

   // Extending both operands to the product width makes one multiplier serve both modes.
   assign w_a_ext = {{DATA_WIDTH{i_signed & i_ifmap[DATA_WIDTH-1]}}, i_ifmap};
   assign w_b_ext = {{DATA_WIDTH{i_signed & i_weight[DATA_WIDTH-1]}}, i_weight};
   assign w_prod  = w_a_ext * w_b_ext;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_prod   <= '0;
         r_psum   <= '0;
         r_signed <= 1'b0;
         r_v1     <= 1'b0;
      end else begin
         r_v1 <= i_fire;
         if (i_fire) begin
            r_prod   <= w_prod;
            r_psum   <= i_psum_en ? i_psum : '0;
            r_signed <= i_signed;
         end
      end
   end

   always_comb begin
      w_prod_ext = r_signed ? PSUM_WIDTH'($signed(r_prod)) : PSUM_WIDTH'(r_prod);
      w_sum      = {1'b0, r_psum} + {1'b0, w_prod_ext};
      w_ovf      = add_ovf(r_signed, r_psum[PSUM_WIDTH-1], w_prod_ext[PSUM_WIDTH-1],
                           w_sum[PSUM_WIDTH-1], w_sum[PSUM_WIDTH]);
      if (!r_signed) begin
         w_sat = '1;
      end else if (r_psum[PSUM_WIDTH-1]) begin
         w_sat = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
      end else begin
         w_sat = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
      end
      w_result = ((SAT != 0) && w_ovf) ? w_sat : w_sum[PSUM_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         o_psum    <= '0;
         o_psum_en <= 1'b0;
         o_ovf     <= 1'b0;
      end else begin
         o_psum_en <= r_v1;
         if (r_v1) begin
            o_psum <= w_result;
            if (w_ovf) begin
               o_ovf <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pe_mc_mac.sv
// Multi-channel weight-streaming PE: stationary ifmap bank with round-robin
// channel pointer, LOAD/READY FSM, forwarding registers and the MAC pipe.
module pe_mc_mac
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int SAT        = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   input  logic                     signed_i,
   input  logic [DATA_WIDTH-1:0]    ifmap_i,
   input  logic                     ifmap_en_i,
   input  logic [DATA_WIDTH-1:0]    weight_i,
   input  logic                     weight_en_i,
   input  logic [PSUM_WIDTH-1:0]    psum_i,
   input  logic                     psum_en_i,
   output logic [DATA_WIDTH-1:0]    ifmap_o,
   output logic                     ifmap_en_o,
   output logic [DATA_WIDTH-1:0]    weight_o,
   output logic                     weight_en_o,
   output logic [PSUM_WIDTH-1:0]    psum_o,
   output logic                     psum_en_o,
   output logic                     ready_o,
   output logic [$clog2(DEPTH)-1:0] ctx_o,
   output logic                     ovf_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   pe_state_e             r_state;
   pe_state_e             w_state_next;
   logic [DATA_WIDTH-1:0] r_bank [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic                  w_fire;

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A reload in READY still lets a same-cycle op fire on the old bank contents.
   always_comb begin
      w_state_next = r_state;
      w_fire       = 1'b0;
      if (ifmap_en_i) begin
         if (r_state == LOAD) begin
            if (r_wr_ptr == LAST) begin
               w_state_next = READY;
            end
         end else begin
            w_state_next = LOAD;
         end
      end
      if (weight_en_i && (r_state == READY)) begin
         w_fire = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_bank[i] <= '0;
         end
      end else begin
         if (ifmap_en_i) begin
            r_bank[r_wr_ptr] <= ifmap_i;
            r_wr_ptr         <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (ifmap_en_i && (r_state == READY)) begin
            r_rd_ptr <= '0;
         end else if (w_fire) begin
            r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PTR_W'(1);
         end
      end
   end

   // Forwarding keeps the array streaming through a soft clear, so only rst_n stops it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ifmap_o     <= '0;
         ifmap_en_o  <= 1'b0;
         weight_o    <= '0;
         weight_en_o <= 1'b0;
      end else begin
         ifmap_o     <= ifmap_i;
         ifmap_en_o  <= ifmap_en_i;
         weight_o    <= weight_i;
         weight_en_o <= weight_en_i;
      end
   end

   pe_mac_pipe #(
      .DATA_WIDTH(DATA_WIDTH),
      .PSUM_WIDTH(PSUM_WIDTH),
      .SAT       (SAT)
   ) u_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (clear_i),
      .i_fire   (w_fire),
      .i_signed (signed_i),
      .i_ifmap  (r_bank[r_rd_ptr]),
      .i_weight (weight_i),
      .i_psum   (psum_i),
      .i_psum_en(psum_en_i),
      .o_psum   (psum_o),
      .o_psum_en(psum_en_o),
      .o_ovf    (ovf_o)
   );

   assign ready_o = (r_state == READY);
   assign ctx_o   = r_rd_ptr;

endmodule

// File: tb/tb_pe_mc_mac.sv
// Directed bench for pe_mc_mac: a 32-bit PE for the main sequence plus two
// 16-bit PEs (saturating and wrapping) for the overflow cases.
module tb_pe_mc_mac;

   logic        clk = 1'b0;
   logic        rstN;
   logic        rst16N;
   logic        clearI;
   logic        signedI;
   logic [7:0]  ifmapI;
   logic        ifmapEnI;
   logic [7:0]  weightI;
   logic        weightEnI;
   logic [31:0] psumI;
   logic [15:0] psum16I;
   logic        psumEnI;

   logic [7:0]  ifmapO, weightO;
   logic        ifmapEnO, weightEnO, psumEnO, readyO, ovfO;
   logic [31:0] psumO;
   logic [1:0]  ctxO;

   logic [7:0]  satIfmapO, satWeightO, wrapIfmapO, wrapWeightO;
   logic        satIfmapEnO, satWeightEnO, satPsumEnO, satReadyO, satOvfO;
   logic        wrapIfmapEnO, wrapWeightEnO, wrapPsumEnO, wrapReadyO, wrapOvfO;
   logic [15:0] satPsumO, wrapPsumO;
   logic [1:0]  satCtxO, wrapCtxO;

   int nChecks = 0;
   int nPass   = 0;

   always #5 clk = ~clk;

   pe_mc_mac #(.DATA_WIDTH(8), .PSUM_WIDTH(32), .DEPTH(4), .SAT(1)) dut (
      .clk(clk), .rst_n(rstN), .clear_i(clearI), .signed_i(signedI),
      .ifmap_i(ifmapI), .ifmap_en_i(ifmapEnI), .weight_i(weightI), .weight_en_i(weightEnI),
      .psum_i(psumI), .psum_en_i(psumEnI),
      .ifmap_o(ifmapO), .ifmap_en_o(ifmapEnO), .weight_o(weightO), .weight_en_o(weightEnO),
      .psum_o(psumO), .psum_en_o(psumEnO), .ready_o(readyO), .ctx_o(ctxO), .ovf_o(ovfO)
   );

   pe_mc_mac #(.DATA_WIDTH(8), .PSUM_WIDTH(16), .DEPTH(4), .SAT(1)) dutSat (
      .clk(clk), .rst_n(rst16N), .clear_i(clearI), .signed_i(signedI),
      .ifmap_i(ifmapI), .ifmap_en_i(ifmapEnI), .weight_i(weightI), .weight_en_i(weightEnI),
      .psum_i(psum16I), .psum_en_i(psumEnI),
      .ifmap_o(satIfmapO), .ifmap_en_o(satIfmapEnO), .weight_o(satWeightO),
      .weight_en_o(satWeightEnO), .psum_o(satPsumO), .psum_en_o(satPsumEnO),
      .ready_o(satReadyO), .ctx_o(satCtxO), .ovf_o(satOvfO)
   );

   pe_mc_mac #(.DATA_WIDTH(8), .PSUM_WIDTH(16), .DEPTH(4), .SAT(0)) dutWrap (
      .clk(clk), .rst_n(rst16N), .clear_i(clearI), .signed_i(signedI),
      .ifmap_i(ifmapI), .ifmap_en_i(ifmapEnI), .weight_i(weightI), .weight_en_i(weightEnI),
      .psum_i(psum16I), .psum_en_i(psumEnI),
      .ifmap_o(wrapIfmapO), .ifmap_en_o(wrapIfmapEnO), .weight_o(wrapWeightO),
      .weight_en_o(wrapWeightEnO), .psum_o(wrapPsumO), .psum_en_o(wrapPsumEnO),
      .ready_o(wrapReadyO), .ctx_o(wrapCtxO), .ovf_o(wrapOvfO)
   );

   // Every step lands 1 time unit after a rising edge so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ifEn, input logic [7:0] ifData,
                                input logic wEn, input logic [7:0] wData,
                                input logic pEn, input logic [31:0] pData,
                                input logic sgn);
      ifmapEnI  = ifEn;
      ifmapI    = ifData;
      weightEnI = wEn;
      weightI   = wData;
      psumEnI   = pEn;
      psumI     = pData;
      signedI   = sgn;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) nPass++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   initial begin
      rstN = 1'b0; rst16N = 1'b0; clearI = 1'b0; psum16I = '0;
      ifmapEnI = 1'b0; ifmapI = '0; weightEnI = 1'b0; weightI = '0;
      psumEnI = 1'b0; psumI = '0; signedI = 1'b0;
      tick();
      tick();
      checkOutput("rst_psum",     psumO,             32'd0);
      checkOutput("rst_psum_en",  32'(psumEnO),      32'd0);
      checkOutput("rst_ready",    32'(readyO),       32'd0);
      checkOutput("rst_ctx",      32'(ctxO),         32'd0);
      checkOutput("rst_ovf",      32'(ovfO),         32'd0);
      checkOutput("rst_wen_o",    32'(weightEnO),    32'd0);
      rstN = 1'b1;

      // Test 1: signed bank 7,-3,2,5 then four ops w=5 p=59
      applyStimulus(1'b1, 8'd7, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t1_ifmap_o",   32'(ifmapO),       32'd7);
      checkOutput("t1_ifmap_en_o",32'(ifmapEnO),     32'd1);
      checkOutput("t1_ready_load",32'(readyO),       32'd0);
      applyStimulus(1'b1, 8'hFD, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b1, 8'd2,  1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b1, 8'd5,  1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t1_ready",     32'(readyO),       32'd1);
      checkOutput("t1_ctx0",      32'(ctxO),         32'd0);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'd5, 1'b1, 32'd59, 1'b1);
      checkOutput("t1_ctx1",      32'(ctxO),         32'd1);
      checkOutput("t1_lat_en",    32'(psumEnO),      32'd0);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'd5, 1'b1, 32'd59, 1'b1);
      checkOutput("t1_psum0",     psumO,             32'd94);
      checkOutput("t1_en0",       32'(psumEnO),      32'd1);
      checkOutput("t1_ctx2",      32'(ctxO),         32'd2);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'd5, 1'b1, 32'd59, 1'b1);
      checkOutput("t1_psum1",     psumO,             32'd44);
      checkOutput("t1_ctx3",      32'(ctxO),         32'd3);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'd5, 1'b1, 32'd59, 1'b1);
      checkOutput("t1_psum2",     psumO,             32'd69);
      checkOutput("t1_ctx_wrap",  32'(ctxO),         32'd0);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t1_psum3",     psumO,             32'd84);
      checkOutput("t1_en3",       32'(psumEnO),      32'd1);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t1_idle_en",   32'(psumEnO),      32'd0);
      checkOutput("t1_hold",      psumO,             32'd84);
      checkOutput("t1_no_ovf",    32'(ovfO),         32'd0);

      // Test 5: reload coincides with op; op uses old bank[0]=7, psum_en_i=0 means psum 0
      applyStimulus(1'b1, 8'd9, 1'b1, 8'd2, 1'b0, 32'd123, 1'b1);
      checkOutput("t5_ready_drop",32'(readyO),       32'd0);
      checkOutput("t5_ctx_reset", 32'(ctxO),         32'd0);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t5_psum",      psumO,             32'd14);
      checkOutput("t5_en",        32'(psumEnO),      32'd1);

      // Test 2: weights in LOAD are forwarded only
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h33, 1'b1, 32'd1, 1'b1);
      checkOutput("t2_weight_o",  32'(weightO),      32'h33);
      checkOutput("t2_wen_o",     32'(weightEnO),    32'd1);
      checkOutput("t2_ready",     32'(readyO),       32'd0);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h44, 1'b1, 32'd1, 1'b1);
      checkOutput("t2_weight_o2", 32'(weightO),      32'h44);
      checkOutput("t2_no_psum",   32'(psumEnO),      32'd0);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t2_wen_low",   32'(weightEnO),    32'd0);
      checkOutput("t2_no_psum2",  32'(psumEnO),      32'd0);

      // Test 3: soft clear, then unsigned vs signed on 0xFF * 2
      clearI = 1'b1;
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h5A, 1'b0, 32'd0, 1'b1);
      clearI = 1'b0;
      checkOutput("t3_clr_psum",  psumO,             32'd0);
      checkOutput("t3_clr_ready", 32'(readyO),       32'd0);
      checkOutput("t3_clr_fwd",   32'(weightO),      32'h5A);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'hFF, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
      end
      checkOutput("t3_ready",     32'(readyO),       32'd1);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h02, 1'b1, 32'd0, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h02, 1'b1, 32'd0, 1'b1);
      checkOutput("t3_unsigned",  psumO,             32'd510);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t3_signed",    psumO,             32'hFFFF_FFFE);
      checkOutput("t3_no_ovf",    32'(ovfO),         32'd0);

      // Test 4: 16-bit psum, 32767 + 35 overflows
      rst16N = 1'b1;
      applyStimulus(1'b1, 8'd7, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      end
      checkOutput("t4_ready",     32'(satReadyO),    32'd1);
      psum16I = 16'd32767;
      applyStimulus(1'b0, 8'd0, 1'b1, 8'd5, 1'b1, 32'd0, 1'b1);
      psum16I = '0;
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t4_sat_psum",  32'(satPsumO),     32'h7FFF);
      checkOutput("t4_sat_ovf",   32'(satOvfO),      32'd1);
      checkOutput("t4_wrap_psum", 32'(wrapPsumO),    32'h8022);
      checkOutput("t4_wrap_ovf",  32'(wrapOvfO),     32'd1);
      checkOutput("t4_main_psum", psumO,             32'd35);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t4_sat_sticky",32'(satOvfO),      32'd1);
      checkOutput("t4_wrap_stky", 32'(wrapOvfO),     32'd1);

      // Test 6: reset with an op in flight and another presented
      applyStimulus(1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 32'd1, 1'b1);
      rstN = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 32'd1, 1'b1);
      checkOutput("t6_psum_en",   32'(psumEnO),      32'd0);
      checkOutput("t6_psum",      psumO,             32'd0);
      checkOutput("t6_ready",     32'(readyO),       32'd0);
      checkOutput("t6_ctx",       32'(ctxO),         32'd0);
      checkOutput("t6_wen_o",     32'(weightEnO),    32'd0);
      rstN = 1'b1;
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t6_drop1",     32'(psumEnO),      32'd0);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t6_drop2",     32'(psumEnO),      32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
